// File: rtl/cnn_acc_pkg.sv
// Shared definitions for the partial-sum accumulator: default widths,
// FSM state encoding and output saturation limits.
package cnn_acc_pkg;

   localparam int unsigned DATA_IN_WIDTH_DEF  = 9;
   localparam int unsigned ACC_WIDTH_DEF      = 20;
   localparam int unsigned DATA_OUT_WIDTH_DEF = 9;
   localparam int unsigned CH_COUNT_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_OUTPUT = 2'd2
   } acc_state_e;

   // Largest value representable in a w-bit signed word
   function automatic longint sat_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Smallest value representable in a w-bit signed word
   function automatic longint sat_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/acc_sat_relu.sv
// Combinational clamp of the wide accumulator to the output pixel width.
// Optional ReLU ahead of the clamp when PSUM_ACC_RELU_EN is defined.
module acc_sat_relu
   import cnn_acc_pkg::*;
#(
   parameter int unsigned ACC_WIDTH      = ACC_WIDTH_DEF,
   parameter int unsigned DATA_OUT_WIDTH = DATA_OUT_WIDTH_DEF
) (
   input  logic signed [ACC_WIDTH-1:0]      acc,
   output logic signed [DATA_OUT_WIDTH-1:0] sat_c
);

   localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(DATA_OUT_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(DATA_OUT_WIDTH));

   // Clamp (and optionally rectify) the accumulator
   always_comb begin
      sat_c = '0;
`ifdef PSUM_ACC_RELU_EN
      if (acc[ACC_WIDTH-1]) begin
         sat_c = '0;
      end else if (acc > SAT_HI) begin
         sat_c = DATA_OUT_WIDTH'(SAT_HI);
      end else begin
         sat_c = DATA_OUT_WIDTH'(acc);
      end
`else
      if (acc > SAT_HI) begin
         sat_c = DATA_OUT_WIDTH'(SAT_HI);
      end else if (acc < SAT_LO) begin
         sat_c = DATA_OUT_WIDTH'(SAT_LO);
      end else begin
         sat_c = DATA_OUT_WIDTH'(acc);
      end
`endif
   end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums a programmable number of PE channel partial
// sums plus a per-filter bias and emits one saturated output pixel.
// Optional ReLU before saturation via macro PSUM_ACC_RELU_EN.
module psum_accumulator
   import cnn_acc_pkg::*;
#(
   parameter int unsigned DATA_IN_WIDTH  = DATA_IN_WIDTH_DEF,
   parameter int unsigned ACC_WIDTH      = ACC_WIDTH_DEF,
   parameter int unsigned DATA_OUT_WIDTH = DATA_OUT_WIDTH_DEF,
   parameter int unsigned CH_COUNT_WIDTH = CH_COUNT_WIDTH_DEF
) (
   input  logic                             ACC_Clk,
   input  logic                             ACC_Reset,
   input  logic [CH_COUNT_WIDTH-1:0]        ACC_Num_Ch,
   input  logic signed [DATA_OUT_WIDTH-1:0] ACC_Bias,
   input  logic                             ACC_In_Valid,
   output logic                             ACC_In_Ready,
   input  logic signed [DATA_IN_WIDTH-1:0]  ACC_In_Data,
   output logic                             ACC_Out_Valid,
   input  logic                             ACC_Out_Ready,
   output logic signed [DATA_OUT_WIDTH-1:0] ACC_Out_Data,
   output logic                             ACC_Busy
);

   // The accumulator must hold the worst-case channel sum without wrapping
   generate
      if (ACC_WIDTH < DATA_IN_WIDTH + CH_COUNT_WIDTH + 1) begin : g_acc_width_check
         $error("psum_accumulator: ACC_WIDTH too small for DATA_IN_WIDTH and CH_COUNT_WIDTH");
      end
      if (ACC_WIDTH < DATA_OUT_WIDTH) begin : g_out_width_check
         $error("psum_accumulator: ACC_WIDTH must be at least DATA_OUT_WIDTH");
      end
   endgenerate

   acc_state_e                      state_q, state_d;
   logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
   logic [CH_COUNT_WIDTH-1:0]       count_q, count_d;
   logic [CH_COUNT_WIDTH-1:0]       n_q, n_d;
   logic [CH_COUNT_WIDTH-1:0]       count_inc;
   logic [CH_COUNT_WIDTH-1:0]       n_first;
   logic                            beat;
   logic                            out_hs;
   logic                            load_out;
   logic signed [DATA_OUT_WIDTH-1:0] sat_c;

   // Saturation of the value about to be registered as the result
   acc_sat_relu #(
      .ACC_WIDTH      (ACC_WIDTH),
      .DATA_OUT_WIDTH (DATA_OUT_WIDTH)
   ) u_sat (
      .acc   (acc_d),
      .sat_c (sat_c)
   );

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      count_d   = count_q;
      n_d       = n_q;
      load_out  = 1'b0;
      beat      = ACC_In_Valid & ACC_In_Ready;
      out_hs    = ACC_Out_Valid & ACC_Out_Ready;
      count_inc = count_q + 1'b1;
      n_first   = (ACC_Num_Ch == '0) ? CH_COUNT_WIDTH'(1) : ACC_Num_Ch;

      case (state_q)
         ST_IDLE: begin
            if (beat) begin
               acc_d   = ACC_WIDTH'(ACC_Bias) + ACC_WIDTH'(ACC_In_Data);
               count_d = CH_COUNT_WIDTH'(1);
               n_d     = n_first;
               state_d = (n_first == CH_COUNT_WIDTH'(1)) ? ST_OUTPUT : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (beat) begin
               acc_d   = acc_q + ACC_WIDTH'(ACC_In_Data);
               count_d = count_inc;
               if (count_inc == n_q) begin
                  state_d = ST_OUTPUT;
               end
            end
         end
         ST_OUTPUT: begin
            if (out_hs) begin
               acc_d   = '0;
               count_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      load_out = (state_q != ST_OUTPUT) && (state_d == ST_OUTPUT);
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge ACC_Clk) begin
      if (ACC_Reset) begin
         state_q       <= ST_IDLE;
         acc_q         <= '0;
         count_q       <= '0;
         n_q           <= '0;
         ACC_In_Ready  <= 1'b0;
         ACC_Out_Valid <= 1'b0;
         ACC_Out_Data  <= '0;
         ACC_Busy      <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         count_q       <= count_d;
         n_q           <= n_d;
         ACC_In_Ready  <= (state_d != ST_OUTPUT);
         ACC_Out_Valid <= (state_d == ST_OUTPUT);
         ACC_Busy      <= (state_d != ST_IDLE);
         if (load_out) begin
            ACC_Out_Data <= sat_c;
         end
      end
   end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream stage of the PE column; consumes PE_Out partial sums, one per input channel.
- Accumulates a programmable number of channel partial sums, adds a per-filter bias, saturates to the output pixel width, and presents one output-feature pixel per accumulation.
- Uses a valid/ready handshake on both sides.
- Sits between the PE array output and the output-feature-map writer.

Parameters:
- DATA_IN_WIDTH, 9: signed width of incoming PE partial sum (matches PE DATA_OUT_WIDTH).
- ACC_WIDTH, 20: signed accumulator width; must be >= DATA_IN_WIDTH+CH_COUNT_WIDTH+1 (elaboration error otherwise).
- DATA_OUT_WIDTH, 9: signed width of output pixel.
- CH_COUNT_WIDTH, 8: width of channel-count input.

Ports:
- ACC_Clk  in  1  clock, rising edge.
- ACC_Reset  in  1  synchronous, active-high reset.
- ACC_Num_Ch  in  CH_COUNT_WIDTH  channels per output pixel; sampled on first accepted beat; 0 treated as 1.
- ACC_Bias  in  DATA_OUT_WIDTH  signed bias; sampled on first accepted beat.
- ACC_In_Valid  in  1  partial sum valid.
- ACC_In_Ready  out  1  block can accept a partial sum.
- ACC_In_Data  in  DATA_IN_WIDTH  signed partial sum from PE.
- ACC_Out_Valid  out  1  result valid.
- ACC_Out_Ready  in  1  downstream accepts result.
- ACC_Out_Data  out  DATA_OUT_WIDTH  saturated signed result.
- ACC_Busy  out  1  high in ACCUM or OUTPUT.

Behaviour:
- Clock and reset: single clock ACC_Clk. ACC_Reset is synchronous, active-high.
- Reset values: state=IDLE, acc=0, count=0, ACC_In_Ready=0 during reset cycle, then 1 in IDLE; ACC_Out_Valid=0, ACC_Out_Data=0, ACC_Busy=0.
- Beat transfer: a beat transfers on a rising edge with In_Valid&In_Ready. A result transfers on Out_Valid&Out_Ready.
- IDLE:
  - In_Ready=1.
  - On a beat: acc <= sext(Bias)+sext(In_Data); count <= 1; latch n = max(Num_Ch,1).
  - If n==1, go to OUTPUT; else go to ACCUM.
- ACCUM:
  - In_Ready=1.
  - Each beat: acc <= acc+sext(In_Data); count <= count+1.
  - When count+1==n on a beat, go to OUTPUT.
  - No beat means hold.
- OUTPUT:
  - In_Ready=0 and In_Valid is ignored.
  - Out_Valid=1; Out_Data = sat(acc) registered on the transition edge, stable until handshake.
  - On handshake: go to IDLE, acc=0, count=0, Out_Valid=0 next cycle.
- Latency: final beat accepted at edge N; Out_Valid and Out_Data valid after edge N.
  - Minimum throughput is one result per n+1 cycles; no overlap between OUTPUT and the next first beat.
- Saturation: clamp acc to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1]. Defaults: [-256, 255].
- Accumulator wraps two's complement internally; the parameter constraint guarantees no wrap for legal n.
- Num_Ch and Bias changes mid-accumulation have no effect.
- Reset mid-operation: any state goes to IDLE on that edge; partial sum discarded; Out_Valid=0 after the edge.
- Simultaneous reset and handshake: reset wins; no result counted.

Optional Feature:
- Macro PSUM_ACC_RELU_EN.
- Defined: ReLU applied before saturation. Negative acc yields 0, so Out_Data is in [0, 255].
- Undefined: signed saturation only; negative results pass through, clamped at -256.

Decomposition:
- Shared package cnn_acc_pkg holds:
  - state encoding constants (IDLE, ACCUM, OUTPUT);
  - default width constants;
  - a function computing the saturation limits from DATA_OUT_WIDTH.
- One natural sub-module: acc_sat_relu, a combinational ACC_WIDTH-to-DATA_OUT_WIDTH clamp plus optional ReLU. It is instantiated once, ahead of the output register.

Test Plan:
- Basic accumulation: Num_Ch=3, Bias=0, beats 10,20,30 back-to-back, Out_Ready=1 -> Out_Data=60, Out_Valid for 1 cycle after the third beat edge; In_Ready=0 in that cycle.
- Positive saturation: Num_Ch=4, Bias=5, four beats of 200 -> acc=805, Out_Data=255.
- Negative result: Num_Ch=2, Bias=3, beats -6,-5 (PE values 5*-2+4 and 6*-2+7 style) -> acc=-8.
  - With PSUM_ACC_RELU_EN: Out_Data=0.
  - Without: Out_Data=-8 (9'h1F8).
  - Also beats -200,-200 without the macro -> Out_Data=-256.
- Backpressure: after Num_Ch=2 beats 7,8, hold Out_Ready=0 for 5 cycles while pulsing In_Valid with data 99 -> Out_Valid stays 1, Out_Data stays 15, In_Ready stays 0, the 99 beats are ignored; Out_Ready=1 -> IDLE next cycle.
- Reset mid-op: Num_Ch=4, beats 50,50, assert ACC_Reset 1 cycle -> Out_Valid=0, Busy=0. Then Num_Ch=2, beats 1,2 -> Out_Data=3.
- Edge counts:
  - Num_Ch=0, Bias=-1, beat 10 -> Out_Data=9 after one beat.
  - Num_Ch=255, all beats 1, Bias=0 -> 255.
  - Two back-to-back Num_Ch=1 ops -> results separated by exactly 2 cycles.
